bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential binary-to-BCD converter using shift-and-add-3
//             (double dabble), one input bit per clock, MSB first. Latency
//             is fixed at WIDTH+1 edges from acceptance to out_valid.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid/ready  - input handshake (ready only while idle)
//             in_data         - unsigned binary value, WIDTH bits
//             out_valid/ready - result handshake (valid only while done)
//             out_bcd         - packed BCD, digit 0 (units) in [3:0]
//             out_ovf         - value did not fit in DIGITS digits
//             out_ndig        - number of significant digits, 1..DIGITS
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic [3:0]            out_ndig
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [3:0]         r_ndig;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shifted;
    logic               w_carry;
    logic [3:0]         w_ndig;

    // Add 3 to every digit that is 5 or more so the following doubling
    // carries correctly into the next decimal digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                 (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
    end

    // The bit leaving the top digit is a multiple of 10^DIGITS; dropping it
    // leaves the value modulo 10^DIGITS and flags overflow.
    assign w_carry   = w_adj[BCD_W-1];
    assign w_shifted = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};

    // Significant digit count of the finished conversion.
    always_comb begin
        w_ndig = 4'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_ndig = 4'(i + 1);
            end
        end
        if (r_ovf) begin
            w_ndig = 4'(DIGITS);
        end
    end

    // SHIFT performs WIDTH shift cycles, then one more cycle to register the
    // digit count, giving out_valid exactly WIDTH+1 edges after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_ndig  <= 4'd1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= in_data;
                        r_cnt   <= '0;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_ndig  <= w_ndig;
                        r_state <= DONE;
                    end else begin
                        r_bcd <= w_shifted;
                        r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_bcd   = r_bcd;
    assign out_ovf   = r_ovf;
    assign out_ndig  = r_ndig;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Self-checking bench for bin2bcd_seq. Two instances (5 and 4
//             digits) share all inputs and are compared against a decimal
//             reference model built from division and modulo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic        in_ready,  out_valid,  out_ovf;
    logic [19:0] out_bcd;
    logic [3:0]  out_ndig;
    logic        in_ready4, out_valid4, out_ovf4;
    logic [15:0] out_bcd4;
    logic [3:0]  out_ndig4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .out_ndig(out_ndig)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_bcd(out_bcd4), .out_ovf(out_ovf4), .out_ndig(out_ndig4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int nd);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_ovf(input longint unsigned v, input int nd);
        return (v >= pow10(nd)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] ref_ndig(input longint unsigned v, input int nd);
        int n;
        longint unsigned t;
        if (v >= pow10(nd)) return 64'(nd);
        n = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        return 64'(n);
    endfunction

    task automatic check_results(input string tag, input logic [15:0] v);
        check({tag, "_bcd5"},  out_bcd,   ref_bcd(v, 5));
        check({tag, "_ovf5"},  out_ovf,   ref_ovf(v, 5));
        check({tag, "_ndig5"}, out_ndig,  ref_ndig(v, 5));
        check({tag, "_bcd4"},  out_bcd4,  ref_bcd(v, 4));
        check({tag, "_ovf4"},  out_ovf4,  ref_ovf(v, 4));
        check({tag, "_ndig4"}, out_ndig4, ref_ndig(v, 4));
    endtask

    // Called #1 after a rising edge with both instances idle.
    task automatic convert(input logic [15:0] v, input int hold);
        int lat;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 17);
        check("out_valid4", out_valid4, 1);
        check_results("result", v);
        // Hold the result with fresh data offered; nothing may change.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check_results("hold", v);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    initial begin
        logic [15:0] v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bcd",       out_bcd,   0);
        check("rst_ovf",       out_ovf,   0);
        check("rst_ndig",      out_ndig,  1);
        rst = 1'b0;

        // Directed values, including the 4-digit overflow boundary.
        convert(16'd65535, 0);
        convert(16'd0,     0);
        convert(16'd12345, 0);
        convert(16'd9,     0);
        convert(16'd10000, 0);
        convert(16'd9999,  0);
        convert(16'd10,    0);
        convert(16'd4321, 10);

        // Reset wins over in_valid in IDLE: nothing is accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd777;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rstprio_ready", in_ready, 1);

        // Reset during the seventh shift cycle aborts the conversion.
        in_valid = 1'b1;
        in_data  = 16'd12345;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_ready", in_ready,  1);
        check("midrst_valid", out_valid, 0);
        check("midrst_bcd",   out_bcd,   0);
        check("midrst_ovf",   out_ovf,   0);
        check("midrst_ndig",  out_ndig,  1);
        convert(16'd255, 0);
        check("after255_bcd_const", out_bcd, 20'h00255);

        // Random regression.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 99));
                1:       v = 16'($urandom_range(9990, 10010));
                default: v = 16'($urandom);
            endcase
            convert(v, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
